bringup_seq: RTL and testbench

BRINGUP_SEQ -- requirements
Module: bringup_seq

---
 rtl/bringup_seq.sv | 161 ++++++++++++++++
 tb/tb_bringup_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bringup_seq.sv
// Power/clock bring-up sequencer: lock filter, PHY reset, staged enables
// with per-stage ack timeout, retry, lock-loss and soft-reset handling.
module bringup_seq #(
    parameter int N_STAGE     = 4,
    parameter int LOCK_FILT   = 1024,
    parameter int PHY_RST_CYC = 250000,
    parameter int GAP_CYC     = 1000,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int RETRY_MAX   = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clk_locked,
    input  logic [N_STAGE-1:0] stage_ok,
    input  logic               soft_reset,
    output logic               phy_rstn,
    output logic [N_STAGE-1:0] stage_en,
    output logic               ready,
    output logic               fault,
    output logic [2:0]         state,
    output logic [3:0]         retry_cnt,
    output logic [7:0]         lock_loss_cnt
);

    localparam int MAX_A  = (LOCK_FILT > PHY_RST_CYC) ? LOCK_FILT : PHY_RST_CYC;
    localparam int MAX_B  = (GAP_CYC > ACK_TIMEOUT) ? GAP_CYC : ACK_TIMEOUT;
    localparam int MAX_TC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW     = $clog2(MAX_TC + 1);
    localparam int KW     = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        PHY_RST   = 3'd1,
        GAP       = 3'd2,
        WAIT_ACK  = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t        st;
    logic          lock_meta;
    logic          lock_s;
    logic [1:0]    rst_q;
    logic [CW-1:0] cnt;
    logic [KW-1:0] k;

    assign state = st;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st            <= WAIT_LOCK;
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            rst_q         <= 2'b00;
            cnt           <= '0;
            k             <= '0;
            phy_rstn      <= 1'b0;
            stage_en      <= '0;
            ready         <= 1'b0;
            fault         <= 1'b0;
            retry_cnt     <= 4'd0;
            lock_loss_cnt <= 8'd0;
        end else begin
            lock_meta <= clk_locked;
            lock_s    <= lock_meta;
            rst_q     <= {rst_q[0], 1'b1};
            // FSM held idle for two edges after reset release
            if (rst_q[1]) begin
                if (soft_reset) begin
                    st        <= WAIT_LOCK;
                    cnt       <= '0;
                    k         <= '0;
                    phy_rstn  <= 1'b0;
                    stage_en  <= '0;
                    ready     <= 1'b0;
                    fault     <= 1'b0;
                    retry_cnt <= 4'd0;
                end else if (!lock_s && st != WAIT_LOCK && st != FAULT) begin
                    st       <= WAIT_LOCK;
                    cnt      <= '0;
                    k        <= '0;
                    phy_rstn <= 1'b0;
                    stage_en <= '0;
                    ready    <= 1'b0;
                    if (lock_loss_cnt != 8'hff)
                        lock_loss_cnt <= lock_loss_cnt + 8'd1;
                end else begin
                    case (st)
                        WAIT_LOCK: begin
                            if (!lock_s) begin
                                cnt <= '0;
                            end else if (cnt == CW'(LOCK_FILT - 1)) begin
                                cnt <= '0;
                                st  <= PHY_RST;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        PHY_RST: begin
                            if (cnt == CW'(PHY_RST_CYC - 1)) begin
                                cnt      <= '0;
                                k        <= '0;
                                phy_rstn <= 1'b1;
                                st       <= GAP;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        GAP: begin
                            if (cnt == CW'(GAP_CYC - 1)) begin
                                cnt         <= '0;
                                stage_en[k] <= 1'b1;
                                st          <= WAIT_ACK;
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        WAIT_ACK: begin
                            if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                                cnt      <= '0;
                                k        <= '0;
                                stage_en <= '0;
                                phy_rstn <= 1'b0;
                                if (retry_cnt < 4'(RETRY_MAX)) begin
                                    retry_cnt <= retry_cnt + 4'd1;
                                    st        <= PHY_RST;
                                end else begin
                                    fault <= 1'b1;
                                    st    <= FAULT;
                                end
                            end else if (stage_ok[k]) begin
                                cnt <= '0;
                                if (k == KW'(N_STAGE - 1)) begin
                                    ready <= 1'b1;
                                    st    <= RUN;
                                end else begin
                                    k  <= k + KW'(1);
                                    st <= GAP;
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        RUN: begin
                            ready <= 1'b1;
                        end
                        FAULT: begin
                            stage_en <= '0;
                            phy_rstn <= 1'b0;
                            fault    <= 1'b1;
                        end
                        default: begin
                            st <= WAIT_LOCK;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bringup_seq.sv
// Directed scoreboard bench for bringup_seq with small timing parameters.
module tb_bringup_seq;

    logic       clk;
    logic       rstn;
    logic       clk_locked;
    logic       soft_reset;
    logic [2:0] stage_ok;
    logic [2:0] auto_ok;
    logic [2:0] force_ok;
    logic [2:0] ack_mask;
    logic [2:0] en_d;
    logic       phy_rstn;
    logic [2:0] stage_en;
    logic       ready;
    logic       fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    assign stage_ok = auto_ok | force_ok;

    bringup_seq #(
        .N_STAGE(3), .LOCK_FILT(3), .PHY_RST_CYC(4),
        .GAP_CYC(2), .ACK_TIMEOUT(8), .RETRY_MAX(1)
    ) dut (
        .clk(clk), .rstn(rstn), .clk_locked(clk_locked),
        .stage_ok(stage_ok), .soft_reset(soft_reset),
        .phy_rstn(phy_rstn), .stage_en(stage_en), .ready(ready),
        .fault(fault), .state(state), .retry_cnt(retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget && state !== s; i++) tick(1);
    endtask

    task automatic wait_en(input logic [2:0] v, input int budget);
        for (int i = 0; i < budget && stage_en !== v; i++) tick(1);
    endtask

    // Stage responder: acks each enabled stage about a cycle later
    initial begin
        auto_ok = 3'b000;
        en_d    = 3'b000;
        forever begin
            @(negedge clk);
            auto_ok = en_d & ack_mask;
            en_d    = stage_en;
        end
    end

    initial begin
        rstn       = 1'b0;
        clk_locked = 1'b0;
        soft_reset = 1'b0;
        force_ok   = 3'b000;
        ack_mask   = 3'b111;
        tick(3);
        push("rst_state", 0); push("rst_phy", 0); push("rst_en", 0);
        push("rst_ready", 0); push("rst_fault", 0); push("rst_retry", 0);
        push("rst_llc", 0);
        check(32'(state)); check(32'(phy_rstn)); check(32'(stage_en));
        check(32'(ready)); check(32'(fault)); check(32'(retry_cnt));
        check(32'(lock_loss_cnt));

        rstn = 1'b1;
        push("nolock_idle", 0);
        tick(6);
        check(32'(state));

        clk_locked = 1'b1;
        push("glitch_hold", 0);
        push("glitch_enter", 1);
        push("glitch_phy_low", 0);
        tick(2);
        clk_locked = 1'b0;
        tick(1);
        clk_locked = 1'b1;
        tick(4);
        check(32'(state));
        tick(1);
        check(32'(state));
        check(32'(phy_rstn));

        push("phy_still_low", 0);
        tick(3);
        check(32'(phy_rstn));
        push("phy_rise", 1); push("gap_state", 2);
        tick(1);
        check(32'(phy_rstn)); check(32'(state));
        push("en_001", 3'b001); push("wack_state", 3);
        tick(2);
        check(32'(stage_en)); check(32'(state));
        push("en_011", 3'b011);
        tick(4);
        check(32'(stage_en));
        push("en_111", 3'b111);
        tick(4);
        check(32'(stage_en));
        push("run_ready", 1); push("run_state", 4);
        tick(2);
        check(32'(ready)); check(32'(state));

        ack_mask   = 3'b101;
        soft_reset = 1'b1;
        push("sr_run_state", 0); push("sr_run_ready", 0);
        tick(1);
        soft_reset = 1'b0;
        check(32'(state)); check(32'(ready));

        push("to_reach_011", 3'b011);
        wait_en(3'b011, 100);
        check(32'(stage_en));
        push("to_pre", 3);
        tick(7);
        check(32'(state));
        push("to1_state", 1); push("to1_retry", 1);
        push("to1_phy", 0); push("to1_en", 0);
        tick(1);
        check(32'(state)); check(32'(retry_cnt));
        check(32'(phy_rstn)); check(32'(stage_en));

        push("fault_state", 5); push("fault_flag", 1);
        push("fault_en", 0); push("fault_phy", 0);
        wait_state(3'd5, 200);
        check(32'(state)); check(32'(fault));
        check(32'(stage_en)); check(32'(phy_rstn));

        ack_mask   = 3'b111;
        soft_reset = 1'b1;
        push("srf_state", 0); push("srf_fault", 0); push("srf_retry", 0);
        tick(1);
        soft_reset = 1'b0;
        check(32'(state)); check(32'(fault)); check(32'(retry_cnt));

        push("relock_run", 4);
        wait_state(3'd4, 200);
        check(32'(state));
        clk_locked = 1'b0;
        push("ll_en", 0); push("ll_phy", 0); push("ll_cnt", 1);
        push("ll_state", 0); push("ll_ready", 0);
        tick(3);
        check(32'(stage_en)); check(32'(phy_rstn)); check(32'(lock_loss_cnt));
        check(32'(state)); check(32'(ready));
        clk_locked = 1'b1;
        push("ll_rerun_en", 3'b111); push("ll_rerun_ready", 1);
        wait_state(3'd4, 200);
        check(32'(stage_en)); check(32'(ready));

        ack_mask   = 3'b000;
        soft_reset = 1'b1;
        tick(1);
        soft_reset = 1'b0;
        push("co_reach", 3'b001);
        wait_en(3'b001, 100);
        check(32'(stage_en));
        soft_reset = 1'b1;
        force_ok   = 3'b001;
        push("co_state", 0); push("co_en", 0);
        tick(1);
        soft_reset = 1'b0;
        force_ok   = 3'b000;
        check(32'(state)); check(32'(stage_en));

        ack_mask = 3'b111;
        push("ar_reach_en", 3'b001); push("ar_reach_gap", 2);
        wait_en(3'b001, 100);
        check(32'(stage_en));
        wait_state(3'd2, 100);
        check(32'(state));
        #2 rstn = 1'b0;
        push("ar_state", 0); push("ar_phy", 0); push("ar_en", 0);
        push("ar_llc", 0); push("ar_ready", 0);
        #1;
        check(32'(state)); check(32'(phy_rstn)); check(32'(stage_en));
        check(32'(lock_loss_cnt)); check(32'(ready));

        @(negedge clk);
        rstn = 1'b1;
        push("rel_hold", 0); push("rel_enter", 1);
        tick(4);
        check(32'(state));
        tick(1);
        check(32'(state));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
